pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
Parametrised, pipelined successor to the single-cycle ALU shifter. It supports SLL, SRL and SRA with the existing ALU_op encoding, and adds ROL and ROR. The datapath width and pipeline depth are configurable. Operands enter through a valid/ready handshake, and results leave through a valid/ready handshake with full backpressure. The block sits in the execute stage beside the ALU and feeds the writeback mux.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of 2, between 8 and 64.
STAGES, 2, number of register stages (the latency); 1 to log2(WIDTH).
SHW, log2(WIDTH), derived localparam; shift-amount width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
A  input  WIDTH  value to be shifted.
B  input  WIDTH  shift amount; only B[SHW-1:0] is used, upper bits are ignored.
ALU_op  input  4  operation code: 4'd2 SLL, 4'd6 SRL, 4'd7 SRA, 4'd12 ROL, 4'd13 ROR; any other code is invalid.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out  output  WIDTH  shift result.
out_op_err  output  1  the result came from an invalid ALU_op.

Behaviour:
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - STAGES register stages, each holding a valid bit, a partial result, the remaining shift amount, the decoded op and the err bit.
  - The log2(WIDTH) barrel levels (shift by 2^i) are split across the stages in ascending i.
  - Each stage gets ceil(SHW/STAGES) levels; the last stage takes the remainder.
  - A level is applied only if its bit in the shift amount is set.
- Level operations:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the original A[WIDTH-1], carried through the stages.
  - ROL / ROR: the bits shifted out re-enter at the opposite end.
- Invalid op: the beat is still accepted and flows through the pipeline. Its result is all zeros and out_op_err = 1.
- Shift amount 0: out equals A for every valid op.
- Latency: exactly STAGES cycles from an accepted input to out_valid when there is no backpressure. Throughput is one beat per cycle.
- Stage advance rule: stage k loads from stage k-1 when stage k is empty or stage k's contents advance in the same cycle.
  - The last stage advances when out_ready = 1.
  - in_ready = stage-0 empty || stage-0 advancing. It is combinational from out_ready through the stage valids and contains no loop through in_valid.
- Bubble collapse: an empty middle stage is filled even while the output is stalled. With out_ready held low, up to STAGES beats are accepted before in_ready falls.
- Ordering: results leave in acceptance order. No beat is dropped or duplicated.
- Output stability: while out_valid && !out_ready, out and out_op_err hold stable.
- Simultaneous events: accept and emit in the same cycle when the pipeline is full and out_ready = 1 is legal, and occupancy is unchanged.
- Reset values: when rst_n = 0 at a clock edge, all stage valids and data registers clear to 0. Outputs become out_valid = 0, out = 0, out_op_err = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-operation: reset mid-operation discards all in-flight beats. A beat presented during the reset cycle is not accepted.
- No combinational path from A, B or ALU_op to out.

Test Plan (WIDTH=32, STAGES=2):
1. SLL, A=0x0000_0001, B=31, out_ready=1 → out=0x8000_0000 and out_valid high exactly 2 cycles after acceptance, out_op_err=0.
2. SRA, A=0x8000_0000, B=0x0000_0024 (effective amount 4) → out=0xF800_0000. SRL with the same operands → out=0x0800_0000.
3. ROR, A=0x0000_00F1, B=4 → out=0x1000_000F. ROL, A=0x8000_0001, B=1 → out=0x0000_0003. Any op with B=0 → out=A.
4. Backpressure: out_ready=0; drive 3 back-to-back SLL beats with B=1, 2, 3 and A=1.
   - in_ready falls after 2 beats are accepted.
   - Raise out_ready → outputs 0x2, 0x4, 0x8 in that order.
   - out is stable during the stall.
5. Invalid op: ALU_op=4'd0, A=0xFFFF_FFFF → out=0, out_op_err=1 after 2 cycles. The next valid beat has out_op_err=0.
6. Reset mid-flight: accept 2 beats, assert rst_n=0 for 1 cycle → out_valid=0, out=0, in_ready=1 afterwards, and no stale result ever appears.

Source files
------------

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready on both sides.
// The log2(WIDTH) shift levels are spread across STAGES register stages.
module pipelined_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_op_err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int LPS = (SHW + STAGES - 1) / STAGES;

    typedef enum logic [2:0] {
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_ROL,
        OP_ROR,
        OP_BAD
    } op_e;

    function automatic op_e decode_op(input logic [3:0] code);
        case (code)
            4'd2:    return OP_SLL;
            4'd6:    return OP_SRL;
            4'd7:    return OP_SRA;
            4'd12:   return OP_ROL;
            4'd13:   return OP_ROR;
            default: return OP_BAD;
        endcase
    endfunction

    // One barrel level; sgn is the original A[MSB] so SRA fills correctly in late stages.
    function automatic logic [WIDTH-1:0] level_shift(input logic [WIDTH-1:0] d, input op_e op,
                                                     input logic sgn, input int sh);
        logic signed [WIDTH:0] ext;
        logic [WIDTH-1:0]      r;
        ext = $signed({sgn, d}) >>> sh;
        case (op)
            OP_SLL:  r = d << sh;
            OP_SRL:  r = d >> sh;
            OP_SRA:  r = ext[WIDTH-1:0];
            OP_ROL:  r = (d << sh) | (d >> (WIDTH - sh));
            OP_ROR:  r = (d >> sh) | (d << (WIDTH - sh));
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [SHW-1:0] amt, input op_e op,
                                                     input logic sgn, input int k);
        logic [WIDTH-1:0] r;
        logic [SHW-1:0]   bits;
        r = d;
        for (int i = 0; i < SHW; i++) begin
            bits = amt >> i;
            if (i >= k * LPS && (i < (k + 1) * LPS || k == STAGES - 1) && bits[0])
                r = level_shift(r, op, sgn, 1 << i);
        end
        return r;
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] err_p;
    logic [STAGES-1:0] sgn_p;
    logic [WIDTH-1:0]  dat_p [STAGES];
    logic [SHW-1:0]    amt_p [STAGES];
    op_e               op_p  [STAGES];

    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] up_vld;
    logic [STAGES-1:0] up_err;
    logic [STAGES-1:0] up_sgn;
    logic [WIDTH-1:0]  up_dat  [STAGES];
    logic [SHW-1:0]    up_amt  [STAGES];
    op_e               up_op   [STAGES];
    logic [WIDTH-1:0]  nxt_dat [STAGES];

    op_e  in_op;
    logic in_err;
    logic unused_bits;

    assign in_op       = decode_op(ALU_op);
    assign in_err      = (in_op == OP_BAD);
    assign unused_bits = ^{B[WIDTH-1:SHW], amt_p[STAGES-1], sgn_p[STAGES-1], op_p[STAGES-1]};

    // A stage can load when it is empty or everything downstream of it moves this cycle.
    always_comb begin
        logic chain;
        ld    = '0;
        chain = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !vld_p[k] || chain;
            chain = ld[k];
        end
    end

    assign in_ready = ld[0];

    always_comb begin
        up_vld[0] = in_valid;
        up_err[0] = in_err;
        up_sgn[0] = A[WIDTH-1] & ~in_err;
        up_dat[0] = in_err ? '0 : A;
        up_amt[0] = B[SHW-1:0];
        up_op[0]  = in_op;
        for (int k = 1; k < STAGES; k++) begin
            up_vld[k] = vld_p[k-1];
            up_err[k] = err_p[k-1];
            up_sgn[k] = sgn_p[k-1];
            up_dat[k] = dat_p[k-1];
            up_amt[k] = amt_p[k-1];
            up_op[k]  = op_p[k-1];
        end
        for (int k = 0; k < STAGES; k++)
            nxt_dat[k] = stage_shift(up_dat[k], up_amt[k], up_op[k], up_sgn[k], k);
    end

    // Stage registers: stage k captures the levels it owns applied to its upstream beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
            err_p <= '0;
            sgn_p <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_p[k] <= '0;
                amt_p[k] <= '0;
                op_p[k]  <= OP_SLL;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    vld_p[k] <= up_vld[k];
                    if (up_vld[k]) begin
                        dat_p[k] <= nxt_dat[k];
                        amt_p[k] <= up_amt[k];
                        op_p[k]  <= up_op[k];
                        err_p[k] <= up_err[k];
                        sgn_p[k] <= up_sgn[k];
                    end
                end
            end
        end
    end

    assign out_valid  = vld_p[STAGES-1];
    assign out        = dat_p[STAGES-1];
    assign out_op_err = err_p[STAGES-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=32, STAGES=2) with directed vectors.
module tb_pipelined_shifter;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;

    localparam logic [3:0] SLL = 4'd2;
    localparam logic [3:0] SRL = 4'd6;
    localparam logic [3:0] SRA = 4'd7;
    localparam logic [3:0] ROL = 4'd12;
    localparam logic [3:0] ROR = 4'd13;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_op_err;

    typedef struct {
        logic [WIDTH-1:0] dat;
        logic             err;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   cyc;
    bit   held_v;
    logic [WIDTH:0] held;

    pipelined_shifter #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (op_a),
        .B         (op_b),
        .ALU_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_op_err(out_op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    // Monitor: samples on the falling edge, pops the scoreboard on each output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !out_ready) begin
                if (held_v) check("stall_stable", {31'd0, out_op_err, out}, {31'd0, held});
                held   = {out_op_err, out};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", {32'd0, out}, {32'd0, e.dat});
                    check("out_op_err", {63'd0, out_op_err}, {63'd0, e.err});
                    if (e.lat) check("latency", 64'(cyc - e.acc), 64'(STAGES));
                end
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] op,
                        input logic [WIDTH-1:0] exp, input logic exp_err, input bit lat);
        bit done;
        exp_t e;
        done     = 1'b0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        alu_op   = op;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.dat = exp;
                e.err = exp_err;
                e.acc = cyc;
                e.lat = lat;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        held_v    = 1'b0;
        held      = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        alu_op    = '0;
        out_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out", {32'd0, out}, 64'd0);
        check("rst_out_op_err", {63'd0, out_op_err}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Basic ops with latency tracking
        send(32'h0000_0001, 32'd31, SLL, 32'h8000_0000, 1'b0, 1'b1);
        drain();
        send(32'h8000_0000, 32'h0000_0024, SRA, 32'hF800_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0024, SRL, 32'h0800_0000, 1'b0, 1'b0);
        send(32'h0000_00F1, 32'd4, ROR, 32'h1000_000F, 1'b0, 1'b0);
        send(32'h8000_0001, 32'd1, ROL, 32'h0000_0003, 1'b0, 1'b0);
        send(32'hDEAD_BEEF, 32'd0, SRA, 32'hDEAD_BEEF, 1'b0, 1'b0);
        send(32'h1234_5678, 32'd0, ROR, 32'h1234_5678, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0020, SLL, 32'h0000_0005, 1'b0, 1'b0);
        send(32'h8000_0000, 32'd31, SRA, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'h0000_0001, 32'd31, ROL, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h0000_0001, 32'd1, ROR, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h7000_0000, 32'd3, SRA, 32'h0E00_0000, 1'b0, 1'b0);
        drain();

        // Backpressure: two beats fill the pipe, the third waits
        out_ready = 1'b0;
        send(32'h1, 32'd1, SLL, 32'h2, 1'b0, 1'b0);
        send(32'h1, 32'd2, SLL, 32'h4, 1'b0, 1'b0);
        in_valid = 1'b1;
        op_a     = 32'h1;
        op_b     = 32'd3;
        alu_op   = SLL;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            check("bp_out_held", {32'd0, out}, 64'h2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_rise", {63'd0, in_ready}, 64'd1);
        if (in_ready) begin
            exp_t e;
            e.dat = 32'h8;
            e.err = 1'b0;
            e.acc = cyc;
            e.lat = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Invalid op codes
        send(32'hFFFF_FFFF, 32'd5, 4'd0, 32'h0, 1'b1, 1'b1);
        send(32'h0000_00F0, 32'd4, SRL, 32'h0000_000F, 1'b0, 1'b0);
        send(32'h8000_0000, 32'd1, 4'd15, 32'h0, 1'b1, 1'b0);
        drain();

        // Reset while two beats are in flight
        out_ready = 1'b0;
        send(32'h1, 32'd4, SLL, 32'h10, 1'b0, 1'b0);
        send(32'h1, 32'd5, SLL, 32'h20, 1'b0, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        op_a     = 32'hABCD_0000;
        op_b     = 32'd4;
        alu_op   = SRL;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out", {32'd0, out}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(6);
        send(32'h0000_0003, 32'd2, SLL, 32'h0000_000C, 1'b0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
